piso_tx: RTL

Parallel-in/serial-out transmitter that converts WIDTH-bit words into a continuous MSB-first bit stream, one bit per clock. It is the transmit end of the SIPO link: its serial_out feeds the SIPO receiver's serial_in, and its frame timing keeps words aligned on WIDTH-cycle boundaries. A valid/ready load handshake allows back-to-back words with no idle cycles between frames.

---
 rtl/piso_sipo_pkg.sv | 18 +
 rtl/piso_bit_counter.sv | 28 ++
 rtl/piso_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/piso_sipo_pkg.sv
// Shared definitions for the PISO transmitter and SIPO receiver so both ends agree
// on state encoding and frame length.
package piso_sipo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // One frame is the data bits, plus one trailing bit when parity is enabled.
  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one frame: cleared on word accept, advanced per data bit,
// flags the final data bit.
module piso_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          at_last
);

  assign at_last = (count == CW'(WIDTH - 1));

  // Clear wins over enable so a word accepted in the last bit cycle starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_tx.sv
// MSB-first parallel-in/serial-out transmitter with a valid/ready load port.
// Define PISO_PARITY_EN to append an even-parity bit after every frame.
module piso_tx
  import piso_sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, next_state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic             at_last;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             parity_acc;
`endif

  // Handshake: a word transfers on the rising edge where load_valid && load_ready.
  // load_ready is a function of state only (idle, or the final bit cycle of a
  // frame), so a producer holding load_valid simply waits for it.
  assign accept = load_valid && load_ready;

  piso_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (state == SHIFT),
    .count   (bit_cnt),
    .at_last (at_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = SHIFT;
      end
      SHIFT: begin
        if (at_last) begin
`ifdef PISO_PARITY_EN
          next_state = PARITY;
`else
          next_state = accept ? SHIFT : IDLE;
`endif
        end
      end
      PARITY: begin
        next_state = accept ? SHIFT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_ready  = 1'b0;
    serial_out  = 1'b0;
    frame_start = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        serial_out  = shift_reg[WIDTH-1];
        frame_start = (bit_cnt == '0);
`ifndef PISO_PARITY_EN
        load_ready  = at_last;
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        serial_out = parity_acc;
        load_ready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (accept) begin
      shift_reg <= load_data;
    end else if (state == SHIFT) begin
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef PISO_PARITY_EN
  // Accumulates the bits as they leave, so it holds the frame's XOR in PARITY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_acc <= 1'b0;
    end else if (accept) begin
      parity_acc <= 1'b0;
    end else if (state == SHIFT) begin
      parity_acc <= parity_acc ^ shift_reg[WIDTH-1];
    end
  end
`endif

endmodule
